// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, synchronous IMEM request path and a DEPTH-entry prefetch FIFO.
// Optional FETCH_PERF_EN adds the saturating stall_cnt / flush_cnt performance counters.
module fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INSN_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic              out_valid,
  output logic [INSN_W-1:0] out_insn,
  output logic [ADDR_W-1:0] out_pc4,
  input  logic              out_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [INSN_W-1:0] mem_insn [DEPTH];
  logic [ADDR_W-1:0] mem_pc4  [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              pop;
  logic              push;
  logic              issue;
  logic [OCC_W-1:0]  occupancy;

  // Decode handshake: an entry transfers on every rising edge where out_valid and
  // out_ready are both high; out_valid depends only on FIFO occupancy, never on out_ready.
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = inflight && !redirect_valid;
  assign out_insn  = mem_insn[rd_ptr];
  assign out_pc4   = mem_pc4[rd_ptr];

  // Counting the in-flight slot reserves room for every outstanding response.
  assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
  assign issue     = rst_n && !redirect_valid && (occupancy < OCC_W'(DEPTH));
  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= RESET_PC;
      inflight    <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_insn[i] <= '0;
        mem_pc4[i]  <= '0;
      end
    end else begin
      inflight    <= issue;
      inflight_pc <= fetch_pc;
      if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
      end
      if (push) begin
        mem_insn[wr_ptr] <= imem_rdata;
        mem_pc4[wr_ptr]  <= inflight_pc + ADDR_W'(4);
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      // A redirect drops queued entries; a coinciding pop has still been handed to decode.
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        count    <= '0;
        rd_ptr   <= wr_ptr;
      end else begin
        count <= count + CNT_W'(push) - CNT_W'(pop);
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  overflow_guard: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count == CNT_W'(DEPTH)));

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      // Only redirects that actually throw work away count as flushes.
      if (redirect_valid && (out_valid || inflight) && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: RAM word n holds value n; each scenario task checks its own outputs.
// Build with FETCH_PERF_EN defined to also exercise the performance counters.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_insn;
  logic [31:0] out_pc4;
  logic        out_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  fetch_queue #(.ADDR_W(32), .INSN_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .out_valid     (out_valid),
    .out_insn      (out_insn),
    .out_pc4       (out_pc4),
    .out_ready     (out_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  // Clock and synchronous instruction RAM model (word n = n).
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= {2'b00, imem_addr[31:2]};
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Ends at cycle 0: #1 after the negedge where rst_n is released.
  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst_n = 1'b0;
    out_ready = rdy;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_req got req=%0b addr=%h exp req=0 addr=0", imem_req, imem_addr);
    end
    checks++;
    if (out_valid !== 1'b0 || out_insn !== 32'h0 || out_pc4 !== 32'h0) begin
      failures++;
      $display("FAIL reset_head got v=%0b insn=%h pc4=%h exp 0/0/0", out_valid, out_insn, out_pc4);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_perf got stall=%0d flush=%0d exp 0/0", stall_cnt, flush_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL cycle0_req got req=%0b addr=%h exp req=1 addr=0", imem_req, imem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL cycle1_valid got %0b exp 0", out_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_insn !== 32'd0 || out_pc4 !== 32'd4) begin
      failures++;
      $display("FAIL cycle2_head got v=%0b insn=%h pc4=%h exp 1/0/4", out_valid, out_insn, out_pc4);
    end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    @(negedge clk); #1;
    for (int c = 2; c < 12; c++) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_insn !== 32'(c - 2) || out_pc4 !== 32'(4 * (c - 1))) begin
        failures++;
        $display("FAIL stream_c%0d got v=%0b insn=%h pc4=%h exp 1/%h/%h",
                 c, out_valid, out_insn, out_pc4, 32'(c - 2), 32'(4 * (c - 1)));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    for (int c = 1; c < 10; c++) begin
      @(negedge clk); #1;
      if (c >= 4) begin
        checks++;
        if (imem_req !== 1'b0) begin
          failures++;
          $display("FAIL bp_req_c%0d got %0b exp 0", c, imem_req);
        end
      end
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_insn !== 32'd0) begin
          failures++;
          $display("FAIL bp_head_c%0d got v=%0b insn=%h exp 1/0", c, out_valid, out_insn);
        end
      end
    end
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_insn !== exp_q[0] || out_pc4 !== (exp_q[0] + 32'd1) * 32'd4) begin
        failures++;
        $display("FAIL bp_drain_%0d got v=%0b insn=%h pc4=%h exp 1/%h/%h",
                 k, out_valid, out_insn, out_pc4, exp_q[0], (exp_q[0] + 32'd1) * 32'd4);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_full_pop();
    do_reset(1'b0);
    repeat (6) @(negedge clk);
    #1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      out_ready = (k % 3 == 0);
      #1;
      checks++;
      if (out_valid !== 1'b1 || imem_req !== out_ready) begin
        failures++;
        $display("FAIL full_req_%0d got v=%0b req=%0b exp v=1 req=%0b", k, out_valid, imem_req, out_ready);
      end
      if (out_ready) begin
        checks++;
        if (out_insn !== exp_q[0]) begin
          failures++;
          $display("FAIL full_order_%0d got insn=%h exp %h", k, out_insn, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    for (int i = 4; i < 12; i++) exp_q.push_back(32'(i));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_insn !== exp_q[0]) begin
        failures++;
        $display("FAIL full_drain_%0d got v=%0b insn=%h exp 1/%h", k, out_valid, out_insn, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL redir_req got %0b exp 0", imem_req);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL redir_next got v=%0b req=%0b addr=%h exp 0/1/100", out_valid, imem_req, imem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h104) begin
      failures++;
      $display("FAIL redir_gap got v=%0b addr=%h exp 0/104", out_valid, imem_addr);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_insn !== 32'h40 + 32'(k) || out_pc4 !== 32'h104 + 32'(4 * k)) begin
        failures++;
        $display("FAIL redir_head_%0d got v=%0b insn=%h pc4=%h exp 1/%h/%h",
                 k, out_valid, out_insn, out_pc4, 32'h40 + 32'(k), 32'h104 + 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect_hold();
    do_reset(1'b1);
    repeat (4) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL hold_req0 got %0b exp 0", imem_req);
    end
    @(negedge clk);
    redirect_pc = 32'h300;
    #1;
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_req1 got req=%0b v=%0b exp 0/0", imem_req, out_valid);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      failures++;
      $display("FAIL hold_last got req=%0b addr=%h exp 1/300", imem_req, imem_addr);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_insn !== 32'hC0 || out_pc4 !== 32'h304) begin
      failures++;
      $display("FAIL hold_head got v=%0b insn=%h pc4=%h exp 1/c0/304", out_valid, out_insn, out_pc4);
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_addr0 got %h exp fffffffc", imem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_addr1 got %h exp 0", imem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_insn !== 32'h3FFF_FFFF || out_pc4 !== 32'h0) begin
      failures++;
      $display("FAIL wrap_head0 got v=%0b insn=%h pc4=%h exp 1/3fffffff/0", out_valid, out_insn, out_pc4);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_insn !== 32'h0 || out_pc4 !== 32'h4) begin
      failures++;
      $display("FAIL wrap_head1 got v=%0b insn=%h pc4=%h exp 1/0/4", out_valid, out_insn, out_pc4);
    end
  endtask

  task automatic test_midreset();
    do_reset(1'b1);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b0 || out_insn !== 32'h0) begin
      failures++;
      $display("FAIL midrst_now got v=%0b req=%0b insn=%h exp 0/0/0", out_valid, imem_req, out_insn);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL midrst_restart got req=%0b addr=%h exp 1/0", imem_req, imem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_stale got v=%0b exp 0", out_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_insn !== 32'h0 || out_pc4 !== 32'h4) begin
      failures++;
      $display("FAIL midrst_head got v=%0b insn=%h pc4=%h exp 1/0/4", out_valid, out_insn, out_pc4);
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset(1'b0);
    repeat (7) @(negedge clk);
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    #1;
    checks++;
    if (stall_cnt !== 32'd5) begin
      failures++;
      $display("FAIL perf_stall5 got %0d exp 5", stall_cnt);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (flush_cnt !== 32'd2) begin
      failures++;
      $display("FAIL perf_flush2 got %0d exp 2", flush_cnt);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (stall_cnt !== 32'd5 || flush_cnt !== 32'd2) begin
      failures++;
      $display("FAIL perf_idle got stall=%0d flush=%0d exp 5/2", stall_cnt, flush_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_full_pop();
    test_redirect();
    test_redirect_hold();
    test_wrap();
    test_midreset();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
